// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAM match scheduler: the default geometry,
// the scheduler state encoding and a popcount used to report the match total.
package cam_pkg;

  localparam int CAM_ENTRIES = 32;
  localparam int CAM_IDX_W   = $clog2(CAM_ENTRIES);

  typedef logic [CAM_ENTRIES-1:0] match_vec_t;
  typedef logic [CAM_IDX_W-1:0]   cam_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  // Works for any vector up to the largest legal ENTRIES (64); callers
  // zero-extend narrower vectors and truncate the result to their count width.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cam_lsb_finder.sv
// Combinational lowest-set-bit finder. Produces the index and one-hot mask of
// the lowest set bit, plus any-set and exactly-one-set flags.
module cam_lsb_finder #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] i_vec,
  output logic [IDX_W-1:0]   o_idx,
  output logic [ENTRIES-1:0] o_onehot,
  output logic               o_any,
  output logic               o_single
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDX_W'(i);
      end
    end
    o_onehot = i_vec & (~i_vec + ENTRIES'(1));
    o_any    = |i_vec;
    o_single = o_any && ((i_vec & (i_vec - ENTRIES'(1))) == '0);
  end

endmodule

// File: rtl/cam_match_scheduler.sv
// Captures one CAM match vector and issues every matching index in ascending
// order, one per valid/ready handshake. Served bits are cleared from the
// pending copy; the index, last flag and one-hot of the next entry to serve
// are computed from the value pending is about to take and registered with it.
//
//   state | meaning
//   IDLE  | ready for a new match vector; zero vectors report miss here
//   ISSUE | presenting indices of the pending vector until empty or flushed
module cam_match_scheduler
  import cam_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               search_valid_i,
  output logic               search_ready_o,
  input  logic [ENTRIES-1:0] match_vec_i,
  output logic               idx_valid_o,
  input  logic               idx_ready_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               idx_last_o,
  output logic [IDX_W:0]     match_count_o,
  output logic               done_o,
  output logic               miss_o,
  input  logic               flush_i
);

  sched_state_e       r_state;
  logic [ENTRIES-1:0] r_pending;
  logic [ENTRIES-1:0] r_onehot;
  logic [IDX_W-1:0]   r_idx;
  logic               r_valid;
  logic               r_last;
  logic               r_done;
  logic               r_miss;
  logic [IDX_W:0]     r_count;

  logic [ENTRIES-1:0] w_pending_nxt;
  logic [ENTRIES-1:0] w_nxt_onehot;
  logic [IDX_W-1:0]   w_nxt_idx;
  logic               w_nxt_any;
  logic               w_nxt_single;
  logic               w_accept;
  logic               w_xfer;

  // Ready is masked by reset so no search can be offered during reset.
  assign search_ready_o = (r_state == IDLE) && !reset;
  assign w_accept       = search_valid_i && search_ready_o;
  // Flush wins over a coincident handshake: that index is not transferred.
  assign w_xfer         = (r_state == ISSUE) && r_valid && idx_ready_i && !flush_i;

  // Value the pending vector takes at the next edge (reset handled in the FSM).
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_state == IDLE) begin
      if (w_accept) begin
        w_pending_nxt = match_vec_i;
      end
    end else if (flush_i) begin
      w_pending_nxt = '0;
    end else if (w_xfer) begin
      w_pending_nxt = r_pending & ~r_onehot;
    end
  end

  cam_lsb_finder #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_finder (
    .i_vec    (w_pending_nxt),
    .o_idx    (w_nxt_idx),
    .o_onehot (w_nxt_onehot),
    .o_any    (w_nxt_any),
    .o_single (w_nxt_single)
  );

  // Scheduler FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_onehot  <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_miss    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_done <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pending <= w_pending_nxt;
            r_onehot  <= w_nxt_onehot;
            r_idx     <= w_nxt_idx;
            r_last    <= w_nxt_single;
            r_valid   <= w_nxt_any;
            r_count   <= (IDX_W + 1)'(popcount(64'(match_vec_i)));
            if (w_nxt_any) begin
              r_state <= ISSUE;
            end else begin
              r_miss <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (flush_i || w_xfer) begin
            r_pending <= w_pending_nxt;
            r_onehot  <= w_nxt_onehot;
            r_idx     <= w_nxt_idx;
            r_last    <= w_nxt_single;
            r_valid   <= w_nxt_any;
            if (!w_nxt_any) begin
              r_state <= IDLE;
            end
            if (w_xfer && r_last) begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign idx_valid_o   = r_valid;
  assign idx_o         = r_idx;
  assign idx_last_o    = r_last;
  assign match_count_o = r_count;
  assign done_o        = r_done;
  assign miss_o        = r_miss;

endmodule

// File: tb/tb_cam_match_scheduler.sv
// Directed bench for cam_match_scheduler with an index scoreboard.
module tb_cam_match_scheduler;

  logic        clk;
  logic        reset;
  logic        search_valid_i;
  logic        search_ready_o;
  logic [31:0] match_vec_i;
  logic        idx_valid_o;
  logic        idx_ready_i;
  logic [4:0]  idx_o;
  logic        idx_last_o;
  logic [5:0]  match_count_o;
  logic        done_o;
  logic        miss_o;
  logic        flush_i;

  typedef struct {
    logic [4:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  cam_match_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .search_valid_i (search_valid_i),
    .search_ready_o (search_ready_o),
    .match_vec_i    (match_vec_i),
    .idx_valid_o    (idx_valid_o),
    .idx_ready_i    (idx_ready_i),
    .idx_o          (idx_o),
    .idx_last_o     (idx_last_o),
    .match_count_o  (match_count_o),
    .done_o         (done_o),
    .miss_o         (miss_o),
    .flush_i        (flush_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    int n;
    int k;
    n = $countones(v);
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        k++;
        exp_q.push_back('{idx: 5'(i), last: (k == n)});
      end
    end
  endtask

  task automatic search(input logic [31:0] v);
    search_valid_i = 1'b1;
    match_vec_i    = v;
    tick();
    search_valid_i = 1'b0;
    match_vec_i    = '0;
  endtask

  // Scoreboard: each handshake that will complete at the next edge pops one entry.
  always @(negedge clk) begin
    if (!reset && idx_valid_o && idx_ready_i && !flush_i) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_idx", 64'(idx_o), 64'(e.idx));
        check("sb_last", 64'(idx_last_o), 64'(e.last));
      end
    end
  end

  initial begin
    int nv;
    int nd;
    reset          = 1'b1;
    search_valid_i = 1'b0;
    match_vec_i    = '0;
    idx_ready_i    = 1'b0;
    flush_i        = 1'b0;
    repeat (2) tick();
    check("rst_ready", search_ready_o, 0);
    check("rst_valid", idx_valid_o, 0);
    check("rst_idx", idx_o, 0);
    check("rst_count", match_count_o, 0);
    check("rst_done", done_o, 0);
    check("rst_miss", miss_o, 0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", search_ready_o, 1);

    // single low bit
    idx_ready_i = 1'b1;
    push_exp(32'h0000_0001);
    search(32'h0000_0001);
    check("t1_valid", idx_valid_o, 1);
    check("t1_idx", idx_o, 0);
    check("t1_last", idx_last_o, 1);
    check("t1_count", match_count_o, 1);
    check("t1_busy", search_ready_o, 0);
    check("t1_no_early_done", done_o, 0);
    tick();
    check("t1_done", done_o, 1);
    check("t1_ready", search_ready_o, 1);
    check("t1_valid_drop", idx_valid_o, 0);
    check("t1_no_miss", miss_o, 0);
    tick();
    check("t1_done_pulse", done_o, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // three hits at full throughput
    push_exp(32'h8000_0011);
    search(32'h8000_0011);
    nv = 0;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      nv += int'(idx_valid_o);
      nd += int'(done_o);
      tick();
    end
    check("t2_valid_cycles", nv, 3);
    check("t2_done_count", nd, 1);
    check("t2_count", match_count_o, 3);
    check("t2_sb_empty", exp_q.size(), 0);

    // miss
    search(32'h0000_0000);
    check("t3_miss", miss_o, 1);
    check("t3_done", done_o, 1);
    check("t3_ready", search_ready_o, 1);
    check("t3_valid", idx_valid_o, 0);
    check("t3_count", match_count_o, 0);
    tick();
    check("t3_miss_pulse", miss_o, 0);
    check("t3_done_pulse", done_o, 0);
    nv = 0;
    for (int c = 0; c < 3; c++) begin
      nv += int'(idx_valid_o);
      tick();
    end
    check("t3_never_valid", nv, 0);
    check("t3_ready_held", search_ready_o, 1);

    // backpressure
    idx_ready_i = 1'b0;
    push_exp(32'h0000_0006);
    search(32'h0000_0006);
    for (int c = 0; c < 3; c++) begin
      check("t4_hold_valid", idx_valid_o, 1);
      check("t4_hold_idx", idx_o, 1);
      check("t4_hold_last", idx_last_o, 0);
      if (c < 2) tick();
    end
    idx_ready_i = 1'b1;
    tick();
    check("t4_idx2", idx_o, 2);
    check("t4_last2", idx_last_o, 1);
    tick();
    check("t4_done", done_o, 1);
    tick();
    check("t4_sb_empty", exp_q.size(), 0);

    // flush during the third transfer
    exp_q.push_back('{idx: 5'd0, last: 1'b0});
    exp_q.push_back('{idx: 5'd1, last: 1'b0});
    search(32'hFFFF_FFFF);
    check("t5_idx0", idx_o, 0);
    check("t5_count", match_count_o, 32);
    tick();
    check("t5_idx1", idx_o, 1);
    tick();
    check("t5_idx2", idx_o, 2);
    check("t5_valid2", idx_valid_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t5_flush_valid", idx_valid_o, 0);
    check("t5_flush_ready", search_ready_o, 1);
    nd = int'(done_o);
    for (int c = 0; c < 3; c++) begin
      tick();
      nd += int'(done_o);
    end
    check("t5_no_done", nd, 0);
    check("t5_sb_empty", exp_q.size(), 0);
    push_exp(32'h0000_0100);
    search(32'h0000_0100);
    check("t5_new_idx", idx_o, 8);
    check("t5_new_last", idx_last_o, 1);
    check("t5_new_count", match_count_o, 1);
    tick();
    check("t5_new_done", done_o, 1);
    tick();

    // reset mid-issue
    idx_ready_i = 1'b0;
    search(32'h00F0_0000);
    check("t6_valid", idx_valid_o, 1);
    check("t6_idx", idx_o, 20);
    check("t6_count", match_count_o, 4);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", idx_valid_o, 0);
    check("t6_rst_idx", idx_o, 0);
    check("t6_rst_last", idx_last_o, 0);
    check("t6_rst_count", match_count_o, 0);
    check("t6_rst_done", done_o, 0);
    check("t6_rst_miss", miss_o, 0);
    check("t6_rst_ready", search_ready_o, 0);
    reset = 1'b0;
    #1;
    check("t6_ready_after", search_ready_o, 1);
    idx_ready_i = 1'b1;
    nv = 0;
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nv += int'(idx_valid_o);
      nd += int'(done_o);
    end
    check("t6_no_stale_idx", nv, 0);
    check("t6_no_done", nd, 0);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
